// File: rtl/banco_reg_pkg.sv
// Shared types and default sizes for the parametrised register bank.
package banco_reg_pkg;

    typedef enum logic {
        OCIOSO,
        LIMPANDO
    } estado_t;

    localparam int LARGURA_PADRAO = 32;
    localparam int NREG_PADRAO    = 4;

endpackage : banco_reg_pkg

// File: rtl/varredura_limpeza.sv
// Clear-sweep controller: walks one register index per cycle after reset or a
// Limpar request and reports busy while the walk is in progress.
module varredura_limpeza
    import banco_reg_pkg::*;
#(
    parameter int NREG = NREG_PADRAO,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          limpar_i,
    output logic          ocupado_o,
    output logic          limpa_en_o,
    output logic [AW-1:0] limpa_idx_o
);

    estado_t       estado_q, estado_d;
    logic [AW-1:0] ptr_q, ptr_d;

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        estado_d = estado_q;
        ptr_d    = ptr_q;
        if (reset_i) begin
            estado_d = LIMPANDO;
            ptr_d    = '0;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (limpar_i) begin
                        estado_d = LIMPANDO;
                        ptr_d    = '0;
                    end
                end
                LIMPANDO: begin
                    if (ptr_q == AW'(NREG - 1)) begin
                        estado_d = OCIOSO;
                        ptr_d    = '0;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
                default: begin
                    estado_d = LIMPANDO;
                    ptr_d    = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        estado_q <= estado_d;
        ptr_q    <= ptr_d;
    end

    // Busy is a pure decode of the state flop, so it carries no input path.
    assign ocupado_o   = (estado_q == LIMPANDO);
    assign limpa_en_o  = (estado_q == LIMPANDO) && !reset_i;
    assign limpa_idx_o = ptr_q;

endmodule : varredura_limpeza

// File: rtl/banco_reg_param.sv
// Register bank with one write port, two registered read ports, optional
// hardwired-zero r0 and optional write-to-read bypass.
module banco_reg_param
    import banco_reg_pkg::*;
#(
    parameter int  LARGURA = LARGURA_PADRAO,
    parameter int  NREG    = NREG_PADRAO,
    parameter bit  R0_ZERO = 1'b0,
    parameter bit  BYPASS  = 1'b1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Escrita,
    input  logic [AW-1:0]      IdReg,
    input  logic [LARGURA-1:0] Dado,
    input  logic [AW-1:0]      Fonte1,
    input  logic [AW-1:0]      Fonte2,
    input  logic               Limpar,
    output logic [LARGURA-1:0] DadoLido1,
    output logic [LARGURA-1:0] DadoLido2,
    output logic               Ocupado
);

    localparam logic [AW:0] NREG_W = (AW + 1)'(NREG);

    function automatic logic idx_valido(input logic [AW-1:0] idx);
        return ({1'b0, idx} < NREG_W);
    endfunction

    logic [LARGURA-1:0] mem [NREG];
    logic               limpa_en;
    logic [AW-1:0]      limpa_idx;
    logic               wr_aceita;
    logic [AW-1:0]      fonte [2];
    logic [LARGURA-1:0] lido_d [2];
    logic [LARGURA-1:0] lido_q [2];

    varredura_limpeza #(
        .NREG (NREG),
        .AW   (AW)
    ) u_varredura (
        .clk_i       (Clock),
        .reset_i     (Reset),
        .limpar_i    (Limpar),
        .ocupado_o   (Ocupado),
        .limpa_en_o  (limpa_en),
        .limpa_idx_o (limpa_idx)
    );

    assign wr_aceita = Escrita && !Ocupado && idx_valido(IdReg) &&
                       !(R0_ZERO && (IdReg == '0));

    // NOTE: the array has no reset; the sweep clears it so it still maps to RAM.
    always_ff @(posedge Clock) begin
        if (limpa_en) begin
            mem[limpa_idx] <= '0;
        end else if (wr_aceita) begin
            mem[IdReg] <= Dado;
        end
    end

    assign fonte[0] = Fonte1;
    assign fonte[1] = Fonte2;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            lido_d[n] = '0;
            if (Reset || !idx_valido(fonte[n]) || (R0_ZERO && (fonte[n] == '0))) begin
                lido_d[n] = '0;
            end else if (BYPASS && wr_aceita && (IdReg == fonte[n])) begin
                lido_d[n] = Dado;
            end else begin
                lido_d[n] = mem[fonte[n]];
            end
        end
    end

    always_ff @(posedge Clock) begin
        lido_q[0] <= lido_d[0];
        lido_q[1] <= lido_d[1];
    end

    assign DadoLido1 = lido_q[0];
    assign DadoLido2 = lido_q[1];

endmodule : banco_reg_param

// File: tb/tb_banco_reg_param.sv
// Directed bench for banco_reg_param: default, no-bypass and r0-zero/NREG=3 builds.
module tb_banco_reg_param;

    logic        Clock = 1'b0;
    logic        Reset, Escrita, Limpar;
    logic [1:0]  IdReg, Fonte1, Fonte2;
    logic [31:0] Dado;

    logic [31:0] d1_a, d2_a, d1_b, d2_b, d1_c, d2_c;
    logic        ocup_a, ocup_b, ocup_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    banco_reg_param u_a (
        .Clock(Clock), .Reset(Reset), .Escrita(Escrita), .IdReg(IdReg), .Dado(Dado),
        .Fonte1(Fonte1), .Fonte2(Fonte2), .Limpar(Limpar),
        .DadoLido1(d1_a), .DadoLido2(d2_a), .Ocupado(ocup_a)
    );

    banco_reg_param #(.BYPASS(1'b0)) u_b (
        .Clock(Clock), .Reset(Reset), .Escrita(Escrita), .IdReg(IdReg), .Dado(Dado),
        .Fonte1(Fonte1), .Fonte2(Fonte2), .Limpar(Limpar),
        .DadoLido1(d1_b), .DadoLido2(d2_b), .Ocupado(ocup_b)
    );

    banco_reg_param #(.R0_ZERO(1'b1), .NREG(3)) u_c (
        .Clock(Clock), .Reset(Reset), .Escrita(Escrita), .IdReg(IdReg), .Dado(Dado),
        .Fonte1(Fonte1), .Fonte2(Fonte2), .Limpar(Limpar),
        .DadoLido1(d1_c), .DadoLido2(d2_c), .Ocupado(ocup_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Escrita = 1'b0; Limpar = 1'b0;
        IdReg = '0; Fonte1 = '0; Fonte2 = '0; Dado = '0;

        tick(); tick();
        check("rst_ocup", 32'(ocup_a), 32'd1);
        check("rst_d1", d1_a, 32'h0);
        check("rst_d2", d2_a, 32'h0);

        Reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("rel_ocup%0d", i), 32'(ocup_a), (i < 4) ? 32'd1 : 32'd0);
        end
        check("rel_ocup_c", 32'(ocup_c), 32'd0);
        check("rel_ocup_b", 32'(ocup_b), 32'd0);

        for (int i = 0; i < 4; i++) begin
            Fonte1 = 2'(i);
            Fonte2 = 2'(i);
            tick();
            check($sformatf("swept_r%0d", i), d1_a, 32'h0);
            check($sformatf("swept_b_r%0d", i), d2_b, 32'h0);
        end

        Escrita = 1'b1; IdReg = 2'd0; Dado = 32'h0000_07E3; Fonte1 = 2'd1; Fonte2 = 2'd1;
        tick();
        Escrita = 1'b0; Fonte1 = 2'd0; Fonte2 = 2'd1;
        tick();
        check("wr_r0_p1", d1_a, 32'h0000_07E3);
        check("wr_r0_p2", d2_a, 32'h0);
        check("r0zero_c", d1_c, 32'h0);

        Escrita = 1'b1; IdReg = 2'd2; Dado = 32'hDEAD_BEEF; Fonte1 = 2'd2;
        tick();
        check("byp_a", d1_a, 32'hDEAD_BEEF);
        check("nobyp_b", d1_b, 32'h0);
        check("byp_c", d1_c, 32'hDEAD_BEEF);
        Escrita = 1'b0;
        tick();
        check("nobyp_b_next", d1_b, 32'hDEAD_BEEF);

        Escrita = 1'b1; IdReg = 2'd0; Dado = 32'h1234_5678; Fonte1 = 2'd0;
        tick();
        check("r0wr_c", d1_c, 32'h0);
        check("r0wr_a", d1_a, 32'h1234_5678);
        check("r0wr_b_old", d1_b, 32'h0000_07E3);
        IdReg = 2'd3; Dado = 32'h0000_0055; Fonte1 = 2'd0; Fonte2 = 2'd3;
        tick();
        check("r0rd_c", d1_c, 32'h0);
        check("oob_byp_c", d2_c, 32'h0);
        check("r3_byp_a", d2_a, 32'h0000_0055);
        check("r0rd_a", d1_a, 32'h1234_5678);
        Escrita = 1'b0;
        tick();
        check("r3_a", d2_a, 32'h0000_0055);
        check("oob_c", d2_c, 32'h0);

        for (int i = 0; i < 4; i++) begin
            Escrita = 1'b1; IdReg = 2'(i); Dado = 32'(i + 1);
            tick();
        end
        Escrita = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Fonte1 = 2'(i);
            tick();
            check($sformatf("fill_r%0d", i), d1_a, 32'(i + 1));
        end

        Limpar = 1'b1;
        tick();
        check("clr_ocup_k", 32'(ocup_a), 32'd1);
        Limpar = 1'b0; Escrita = 1'b1; IdReg = 2'd1; Dado = 32'h0000_00FF; Fonte1 = 2'd1;
        tick();
        check("clr_ocup_k1", 32'(ocup_a), 32'd1);
        check("clr_drop_k1", d1_a, 32'd2);
        Limpar = 1'b1;
        tick();
        check("clr_ocup_k2", 32'(ocup_a), 32'd1);
        check("clr_rd_k2", d1_a, 32'd2);
        Limpar = 1'b0;
        tick();
        check("clr_ocup_k3", 32'(ocup_a), 32'd1);
        check("clr_rd_k3", d1_a, 32'd0);
        tick();
        check("clr_ocup_k4", 32'(ocup_a), 32'd0);
        Escrita = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Fonte1 = 2'(i);
            tick();
            check($sformatf("clr_r%0d", i), d1_a, 32'h0);
        end

        Escrita = 1'b1; IdReg = 2'd3; Dado = 32'h0000_00A5; Limpar = 1'b1; Fonte1 = 2'd3;
        tick();
        check("wr_at_limpar", d1_a, 32'h0000_00A5);
        check("rs_ocup_k", 32'(ocup_a), 32'd1);
        Escrita = 1'b0; Limpar = 1'b0;
        tick();
        check("rs_r3_k1", d1_a, 32'h0000_00A5);
        Reset = 1'b1;
        tick();
        check("rs_ocup_rst", 32'(ocup_a), 32'd1);
        check("rs_d1_rst", d1_a, 32'h0);
        Reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("rs_ocup%0d", i), 32'(ocup_a), (i < 4) ? 32'd1 : 32'd0);
        end
        tick();
        check("rs_r3_after", d1_a, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_banco_reg_param
